// File: rtl/uop_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uop_pkg
// Brief    : Shared front-end uop sizing constants and instruction queue types.
// Revision : 1.0
// ============================================================================
package uop_pkg;

    localparam int INSTR_Q_DEPTH  = 16;
    localparam int INSTR_Q_WIDTH  = 4;
    localparam int DISPATCH_WIDTH = 4;

    typedef enum logic [1:0] {
        IQ_RUN     = 2'd0,
        IQ_FLUSH   = 2'd1,
        IQ_RECOVER = 2'd2
    } iq_ctrl_state_e;

    function automatic int unsigned min3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_queue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_queue_ctrl_if
// Brief    : Decoder, dispatch and queue-control signals of instr_queue_ctrl.
// Revision : 1.0
// ============================================================================
interface instr_queue_ctrl_if #(
    parameter int Q_DEPTH    = uop_pkg::INSTR_Q_DEPTH,
    parameter int Q_WIDTH    = uop_pkg::INSTR_Q_WIDTH,
    parameter int DISP_WIDTH = uop_pkg::DISPATCH_WIDTH
);
    localparam int CW = $clog2(Q_WIDTH + 1);
    localparam int DW = $clog2(DISP_WIDTH + 1);
    localparam int OW = $clog2(Q_DEPTH + 1);

    logic          dec_valid_in;
    logic [CW-1:0] dec_count_in;
    logic          dec_ready_out;
    logic          redirect_in;
    logic [DW-1:0] disp_slots_in;
    logic [CW-1:0] q_enq_out;
    logic [CW-1:0] q_deq_out;
    logic          q_flush_out;
    logic [DW-1:0] disp_count_out;
    logic [OW-1:0] occ_out;
    logic [31:0]   full_stall_cnt_out;
    logic [15:0]   flush_cnt_out;

    // The controller side
    modport slave (
        input  dec_valid_in, dec_count_in, redirect_in, disp_slots_in,
        output dec_ready_out, q_enq_out, q_deq_out, q_flush_out,
               disp_count_out, occ_out, full_stall_cnt_out, flush_cnt_out
    );

    modport master (
        output dec_valid_in, dec_count_in, redirect_in, disp_slots_in,
        input  dec_ready_out, q_enq_out, q_deq_out, q_flush_out,
               disp_count_out, occ_out, full_stall_cnt_out, flush_cnt_out
    );

endinterface
`default_nettype wire

// File: rtl/instr_queue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : instr_queue_ctrl
// Brief    : Enqueue/dequeue/flush sequencer with shadow occupancy for the
//            decode-to-dispatch instruction queue.
// Revision : 1.0
// ============================================================================
module instr_queue_ctrl
    import uop_pkg::*;
#(
    parameter int Q_DEPTH        = INSTR_Q_DEPTH,
    parameter int Q_WIDTH        = INSTR_Q_WIDTH,
    parameter int DISP_WIDTH     = DISPATCH_WIDTH,
    parameter int RECOVER_CYCLES = 2
) (
    input  logic               clk_in,
    input  logic               rst_N_in,
    instr_queue_ctrl_if.slave  bus
);

    localparam int CW = $clog2(Q_WIDTH + 1);
    localparam int DW = $clog2(DISP_WIDTH + 1);
    localparam int OW = $clog2(Q_DEPTH + 1);

    iq_ctrl_state_e state_q, state_d;
    logic [OW-1:0]  occ_q, occ_d;
    logic [1:0]     rc_q, rc_d;
    logic [31:0]    stall_q, stall_d;
    logic [15:0]    flush_cnt_q, flush_cnt_d;

    logic           ready_w;
    logic           flush_w;
    logic [CW-1:0]  enq_w;
    logic [CW-1:0]  deq_w;
    logic [OW:0]    occ_sum_w;
    logic           fits_w;
    logic           fits_rst_w;

    // Space check uses registered occupancy only; same-cycle dequeue is not credited.
    assign occ_sum_w  = {1'b0, occ_q} + (OW+1)'(bus.dec_count_in);
    assign fits_w     = (occ_sum_w <= (OW+1)'(Q_DEPTH));
    assign fits_rst_w = ((OW+1)'(bus.dec_count_in) <= (OW+1)'(Q_DEPTH));

    always_comb begin
        state_d     = state_q;
        occ_d       = occ_q;
        rc_d        = rc_q;
        stall_d     = stall_q;
        flush_cnt_d = flush_cnt_q;
        ready_w     = 1'b0;
        flush_w     = 1'b0;
        enq_w       = '0;
        deq_w       = '0;

        case (state_q)
            IQ_RUN: begin
                if (bus.redirect_in) begin
                    state_d = IQ_FLUSH;
                end else begin
                    ready_w = fits_w;
                    if (bus.dec_valid_in && fits_w) begin
                        enq_w = bus.dec_count_in;
                    end
                    deq_w = CW'(min3(32'(occ_q), 32'(bus.disp_slots_in), 32'(DISP_WIDTH)));
                    occ_d = occ_q + OW'(enq_w) - OW'(deq_w);
                    if (bus.dec_valid_in && !fits_w) begin
                        stall_d = stall_q + 32'd1;
                    end
                end
            end
            IQ_FLUSH: begin
                flush_w     = 1'b1;
                occ_d       = '0;
                flush_cnt_d = flush_cnt_q + 16'd1;
                rc_d        = 2'(RECOVER_CYCLES);
                state_d     = bus.redirect_in ? IQ_FLUSH : IQ_RECOVER;
            end
            IQ_RECOVER: begin
                rc_d = rc_q - 2'd1;
                if (bus.redirect_in) begin
                    state_d = IQ_FLUSH;
                end else if (rc_q <= 2'd1) begin
                    state_d = IQ_RUN;
                end
            end
            default: begin
                state_d = IQ_RUN;
            end
        endcase

        // While reset is held the outputs look like RUN at empty occupancy.
        if (!rst_N_in) begin
            ready_w = fits_rst_w;
            flush_w = 1'b0;
            enq_w   = '0;
            deq_w   = '0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_N_in) begin
            state_q     <= IQ_RUN;
            occ_q       <= '0;
            rc_q        <= '0;
            stall_q     <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            occ_q       <= occ_d;
            rc_q        <= rc_d;
            stall_q     <= stall_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.dec_ready_out      = ready_w;
    assign bus.q_enq_out          = enq_w;
    assign bus.q_deq_out          = deq_w;
    assign bus.q_flush_out        = flush_w;
    assign bus.disp_count_out     = DW'(deq_w);
    assign bus.occ_out            = occ_q;
    assign bus.full_stall_cnt_out = stall_q;
    assign bus.flush_cnt_out      = flush_cnt_q;

    a_count_legal: assert property (@(posedge clk_in) disable iff (!rst_N_in)
        bus.dec_valid_in |-> (bus.dec_count_in <= CW'(Q_WIDTH)));

    a_occ_bound: assert property (@(posedge clk_in) disable iff (!rst_N_in)
        occ_q <= OW'(Q_DEPTH));

endmodule
`default_nettype wire
